// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG entropy-stream byte stuffer.
// FSM encoding, stuffing byte and EOI marker value.
package jpeg_enc_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EOI   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [7:0]  JPEG_STUFF_BYTE = 8'h00;
  localparam logic [15:0] JPEG_EOI        = 16'hFFD9;

endpackage

// File: rtl/jpeg_ff_expand.sv
// Combinational 0xFF expander: emits each valid byte, inserting a stuffing byte after every 0xFF.
// Zero latency; no flow control of its own, the caller registers the result.
module jpeg_ff_expand
  import jpeg_enc_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int BW    = $clog2(LANES + 1),
  localparam int LW    = $clog2(2 * LANES + 1)
) (
  input  logic [8*LANES-1:0]  word_i,
  input  logic [BW-1:0]       bytes_i,
  output logic [16*LANES-1:0] data_o,
  output logic [LW-1:0]       len_o,
  output logic [BW-1:0]       ins_o
);

  always_comb begin
    int pos;
    int nins;
    data_o = '0;
    pos    = 0;
    nins   = 0;
    for (int k = 0; k < LANES; k++) begin
      if (k < 32'(bytes_i)) begin
        data_o[8*pos +: 8] = word_i[8*k +: 8];
        pos++;
        if (word_i[8*k +: 8] == 8'hFF) begin
          data_o[8*pos +: 8] = JPEG_STUFF_BYTE;
          pos++;
          nins++;
        end
      end
    end
    len_o = LW'(pos);
    ins_o = BW'(nins);
  end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Byte stuffer: expand 0xFF -> 0xFF,0x00, optionally append EOI, repack into LANES-byte words.
// Accept-to-output two register stages; s_ready_o is purely registered (buffer room), no path from m_ready_i.
module jpeg_byte_stuffer
  import jpeg_enc_pkg::*;
#(
  parameter  int LANES      = 4,
  parameter  bit APPEND_EOI = 1'b1,
  localparam int BW         = $clog2(LANES + 1)
) (
  input  logic               clk_x8_i,
  input  logic               rst_n_i,
  input  logic [8*LANES-1:0] s_data_i,
  input  logic [BW-1:0]      s_bytes_i,
  input  logic               s_last_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [8*LANES-1:0] m_data_o,
  output logic [BW-1:0]      m_bytes_o,
  output logic               m_last_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [15:0]        stuffed_cnt_o
);

  localparam int LW  = $clog2(2 * LANES + 1);
  localparam int BLW = $clog2(4 * LANES + 1);
  localparam int SW  = BLW + 1;
  localparam logic [15:0] EOI_STREAM = {JPEG_EOI[7:0], JPEG_EOI[15:8]};

  state_e state_q, state_d;
  logic   run_en_q;

  logic                  st1_vld_q, st1_last_q;
  logic [16*LANES-1:0]   st1_dat_q;
  logic [LW-1:0]         st1_len_q;

  logic [32*LANES-1:0]   buf_q, buf_d, buf_sh;
  logic [BLW-1:0]        buf_len_q, buf_len_d, len_sh;
  logic [48*LANES-1:0]   wide;
  logic [SW-1:0]         len_acc;

  logic [8*LANES-1:0]    m_data_q, m_data_d;
  logic [BW-1:0]         m_bytes_q, m_bytes_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [16:0]           cnt_sum;

  logic [16*LANES-1:0]   exp_dat;
  logic [LW-1:0]         exp_len;
  logic [BW-1:0]         exp_ins;

  logic s_fire, m_fire, last_hs, out_free, load_full, load_tail;
  logic room_ok, in_eoi, in_drain, eoi_ok;

  jpeg_ff_expand #(.LANES(LANES)) u_expand (
    .word_i  (s_data_i),
    .bytes_i (s_bytes_i),
    .data_o  (exp_dat),
    .len_o   (exp_len),
    .ins_o   (exp_ins)
  );

  assign s_fire   = s_valid_i && s_ready_o;
  assign m_fire   = m_valid_q && m_ready_i;
  assign last_hs  = m_fire && m_last_q;
  assign out_free = !m_valid_q || m_ready_i;
  // Buffer + pending stage-1 bytes within 2*LANES leaves room for one more expanded word.
  assign room_ok  = (SW'(buf_len_q) + SW'(st1_len_q)) <= SW'(2 * LANES);

  always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= RUN;
      run_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (st1_vld_q && st1_last_q) state_d = APPEND_EOI ? EOI : DRAIN;
      EOI:     if (eoi_ok) state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The final word of an image blocks admission until it has merged, so images never interleave.
  always_comb begin
    s_ready_o = 1'b0;
    in_eoi    = 1'b0;
    in_drain  = 1'b0;
    case (state_q)
      RUN:     s_ready_o = run_en_q && !(st1_vld_q && st1_last_q) && room_ok;
      EOI:     in_eoi = 1'b1;
      DRAIN:   in_drain = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    load_full = out_free && (buf_len_q >= BLW'(LANES));
    load_tail = out_free && in_drain && (buf_len_q != '0) && (buf_len_q < BLW'(LANES));
    buf_sh    = buf_q;
    len_sh    = buf_len_q;
    if (load_full) begin
      buf_sh = buf_q >> (8 * LANES);
      len_sh = buf_len_q - BLW'(LANES);
    end else if (load_tail) begin
      buf_sh = '0;
      len_sh = '0;
    end
    eoi_ok  = in_eoi && ((SW'(len_sh) + SW'(2)) <= SW'(4 * LANES));
    wide    = {{(16*LANES){1'b0}}, buf_sh};
    len_acc = SW'(len_sh);
    if (st1_vld_q) begin
      wide    = wide | ({{(32*LANES){1'b0}}, st1_dat_q} << (8 * len_sh));
      len_acc = len_acc + SW'(st1_len_q);
    end
    if (eoi_ok) begin
      wide    = wide | ({{(48*LANES-16){1'b0}}, EOI_STREAM} << (8 * len_sh));
      len_acc = len_acc + SW'(2);
    end
    buf_d     = wide[32*LANES-1:0];
    buf_len_d = BLW'(len_acc);
  end

  always_comb begin
    m_valid_d = m_valid_q && !m_ready_i;
    m_data_d  = m_data_q;
    m_bytes_d = m_bytes_q;
    m_last_d  = m_last_q;
    if (load_full) begin
      m_valid_d = 1'b1;
      m_data_d  = buf_q[8*LANES-1:0];
      m_bytes_d = BW'(LANES);
      m_last_d  = in_drain && (buf_len_q == BLW'(LANES));
    end else if (load_tail) begin
      m_valid_d = 1'b1;
      m_data_d  = buf_q[8*LANES-1:0];
      m_bytes_d = BW'(buf_len_q);
      m_last_d  = 1'b1;
    end
  end

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 17'(exp_ins);
    cnt_d   = cnt_q;
    if (last_hs) begin
      cnt_d = '0;
    end else if (s_fire) begin
      cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st1_vld_q  <= 1'b0;
      st1_last_q <= 1'b0;
      st1_dat_q  <= '0;
      st1_len_q  <= '0;
      buf_q      <= '0;
      buf_len_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_bytes_q  <= '0;
      m_last_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      st1_vld_q  <= s_fire;
      st1_last_q <= s_fire && s_last_i;
      st1_dat_q  <= s_fire ? exp_dat : '0;
      st1_len_q  <= s_fire ? exp_len : '0;
      buf_q      <= buf_d;
      buf_len_q  <= buf_len_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_bytes_q  <= m_bytes_d;
      m_last_q   <= m_last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m_data_o      = m_data_q;
  assign m_bytes_o     = m_bytes_q;
  assign m_last_o      = m_last_q;
  assign m_valid_o     = m_valid_q;
  assign stuffed_cnt_o = cnt_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Scoreboard bench for jpeg_byte_stuffer: one instance without EOI, one with EOI.
// Stimulus pushes hand-computed output words; per-instance monitors pop and compare.
module tb_jpeg_byte_stuffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] s_dat;
  logic [2:0]  s_bytes;
  logic        s_last, s_vld, sel;
  logic        s_vld0, s_vld1, s_rdy0, s_rdy1;
  logic [31:0] m_dat0, m_dat1;
  logic [2:0]  m_bytes0, m_bytes1;
  logic        m_last0, m_last1, m_vld0, m_vld1, m_rdy0, m_rdy1;
  logic [15:0] cnt0, cnt1;

  assign s_vld0 = s_vld & ~sel;
  assign s_vld1 = s_vld & sel;

  jpeg_byte_stuffer #(.LANES(4), .APPEND_EOI(1'b0)) dut0 (
    .clk_x8_i(clk), .rst_n_i(rst_n),
    .s_data_i(s_dat), .s_bytes_i(s_bytes), .s_last_i(s_last), .s_valid_i(s_vld0), .s_ready_o(s_rdy0),
    .m_data_o(m_dat0), .m_bytes_o(m_bytes0), .m_last_o(m_last0), .m_valid_o(m_vld0), .m_ready_i(m_rdy0),
    .stuffed_cnt_o(cnt0)
  );

  jpeg_byte_stuffer #(.LANES(4), .APPEND_EOI(1'b1)) dut1 (
    .clk_x8_i(clk), .rst_n_i(rst_n),
    .s_data_i(s_dat), .s_bytes_i(s_bytes), .s_last_i(s_last), .s_valid_i(s_vld1), .s_ready_o(s_rdy1),
    .m_data_o(m_dat1), .m_bytes_o(m_bytes1), .m_last_o(m_last1), .m_valid_o(m_vld1), .m_ready_i(m_rdy1),
    .stuffed_cnt_o(cnt1)
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  b;
    logic        l;
    logic        chk_cnt;
    logic [15:0] c;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] b, input logic l,
                      input logic chk, input logic [15:0] c);
    exp_t e;
    e.d = d; e.b = b; e.l = l; e.chk_cnt = chk; e.c = c;
    expq.push_back(e);
  endtask

  task automatic mon(input int id, input logic [31:0] d, input logic [2:0] b,
                     input logic l, input logic [15:0] c);
    exp_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_word dut%0d: got 0x%0h, required no output", id, d);
    end else begin
      e = expq.pop_front();
      check("m_data", d, e.d);
      check("m_bytes", 32'(b), 32'(e.b));
      check("m_last", 32'(l), 32'(e.l));
      if (e.chk_cnt) check("stuffed_cnt", 32'(c), 32'(e.c));
    end
  endtask

  always @(negedge clk) if (rst_n && m_vld0 && m_rdy0) mon(0, m_dat0, m_bytes0, m_last0, cnt0);
  always @(negedge clk) if (rst_n && m_vld1 && m_rdy1) mon(1, m_dat1, m_bytes1, m_last1, cnt1);

  task automatic chk_rst(input string tag, input logic [31:0] d, input logic [2:0] b,
                         input logic l, input logic v, input logic r, input logic [15:0] c);
    check({tag, "_m_data"}, d, 32'h0);
    check({tag, "_m_bytes"}, 32'(b), 32'h0);
    check({tag, "_m_last"}, 32'(l), 32'h0);
    check({tag, "_m_valid"}, 32'(v), 32'h0);
    check({tag, "_s_ready"}, 32'(r), 32'h0);
    check({tag, "_stuffed_cnt"}, 32'(c), 32'h0);
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] b, input logic l);
    int n = 0;
    @(negedge clk);
    s_dat = d; s_bytes = b; s_last = l; s_vld = 1'b1;
    while (!(sel ? s_rdy1 : s_rdy0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready stayed 0, required 1 within 1000 cycles");
    end else begin
      @(posedge clk);
      acc_cnt++;
    end
    #1 s_vld = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (expq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: %0d words outstanding, required 0", tag, expq.size());
      expq.delete();
    end
    repeat (3) @(negedge clk);
    check({tag, "_cnt_cleared"}, 32'(sel ? cnt1 : cnt0), 32'h0);
    check({tag, "_idle_valid"}, 32'(sel ? m_vld1 : m_vld0), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500 us");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic saw_low;
    rst_n = 1'b0; s_dat = '0; s_bytes = '0; s_last = 1'b0; s_vld = 1'b0; sel = 1'b0;
    m_rdy0 = 1'b1; m_rdy1 = 1'b1;
    repeat (2) @(negedge clk);
    chk_rst("rst0", m_dat0, m_bytes0, m_last0, m_vld0, s_rdy0, cnt0);
    chk_rst("rst1", m_dat1, m_bytes1, m_last1, m_vld1, s_rdy1, cnt1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst0", 32'(s_rdy0), 32'h1);
    check("ready_after_rst1", 32'(s_rdy1), 32'h1);

    // Plain data, no stuffing.
    push(32'h03020100, 3'd4, 1'b0, 1'b0, 16'h0);
    push(32'h07060504, 3'd4, 1'b1, 1'b1, 16'h0);
    send(32'h03020100, 3'd4, 1'b0);
    send(32'h07060504, 3'd4, 1'b1);
    wait_drain("plain");

    // Two stuffed bytes, partial final output word.
    push(32'h000000FF, 3'd4, 1'b0, 1'b0, 16'h0);
    push(32'h221100FF, 3'd4, 1'b0, 1'b0, 16'h0);
    push(32'h00004433, 3'd2, 1'b1, 1'b1, 16'h2);
    send(32'hFF0000FF, 3'd4, 1'b0);
    send(32'h44332211, 3'd4, 1'b1);
    wait_drain("stuff2");

    // Single valid byte; upper lanes carry junk that must be dropped.
    push(32'h000000FF, 3'd2, 1'b1, 1'b1, 16'h1);
    send(32'h5A5A5AFF, 3'd1, 1'b1);
    wait_drain("onebyte");

    // EOI append on the second instance.
    sel = 1'b1;
    push(32'h00FF00FF, 3'd4, 1'b0, 1'b0, 16'h0);
    push(32'h00FF00FF, 3'd4, 1'b0, 1'b0, 16'h0);
    push(32'h0000D9FF, 3'd2, 1'b1, 1'b1, 16'h4);
    send(32'hFFFFFFFF, 3'd4, 1'b1);
    wait_drain("eoi");
    sel = 1'b0;

    // Backpressure: 32 all-0xFF words with the sink stalled for 20 cycles.
    for (int i = 0; i < 64; i++) push(32'h00FF00FF, 3'd4, i == 63, i == 63, 16'd128);
    @(posedge clk);
    #1 m_rdy0 = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send(32'hFFFFFFFF, 3'd4, i == 31);
      end
      begin
        a0 = acc_cnt;
        saw_low = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (!s_rdy0) saw_low = 1'b1;
        end
        check("stall_ready_fell", 32'(saw_low), 32'h1);
        check("stall_admit_bounded", 32'((acc_cnt - a0) <= 3), 32'h1);
        @(posedge clk);
        #1 m_rdy0 = 1'b1;
      end
    join
    wait_drain("stall");

    // Reset in the middle of an image, then a clean image.
    @(posedge clk);
    #1 m_rdy0 = 1'b0;
    send(32'h123456FF, 3'd4, 1'b0);
    send(32'hABCDEFFF, 3'd4, 1'b0);
    @(negedge clk);
    check("pre_reset_cnt", 32'(cnt0), 32'h2);
    s_dat = 32'h00FF00FF; s_bytes = 3'd4; s_last = 1'b0; s_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_rst("midrst", m_dat0, m_bytes0, m_last0, m_vld0, s_rdy0, cnt0);
    s_vld = 1'b0;
    @(negedge clk);
    m_rdy0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_cnt", 32'(cnt0), 32'h0);
    push(32'h00FF2233, 3'd4, 1'b0, 1'b0, 16'h0);
    push(32'h55667711, 3'd4, 1'b0, 1'b0, 16'h0);
    push(32'h00000044, 3'd1, 1'b1, 1'b1, 16'h1);
    send(32'h11FF2233, 3'd4, 1'b0);
    send(32'h44556677, 3'd4, 1'b1);
    wait_drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
